stopwatch_ctrl: RTL
===================

Name: stopwatch_ctrl

Overview:
User-input front end for the stopwatch display path. It conditions three raw pushbuttons (start/stop, lap, clear): each button is synchronised, debounced and edge-detected. A small state machine then turns the button events into the control signals consumed by the counter/display datapath: `run` (counter enable), `freeze` (display hold) and `clear` (one-cycle counter clear).

Parameters:
- DEBOUNCE_CYCLES, default 500000: number of consecutive clk cycles a synchronised input must differ from its debounced state before the debounced state flips (10 ms at 50 MHz). Legal range 1 to 2^CNT_W-1.
- CNT_W, default 20: width of each debounce counter.

Ports:
- clk, input, 1: system clock; all state changes on its rising edge.
- reset, input, 1: asynchronous, active-high reset.
- btn_startstop, input, 1: raw start/stop button, asynchronous, active-high.
- btn_lap, input, 1: raw lap button, asynchronous, active-high.
- btn_clear, input, 1: raw clear button, asynchronous, active-high.
- run, output, 1: 1 = counter advances.
- freeze, output, 1: 1 = display registers hold their value while the counter keeps running.
- clear, output, 1: one-cycle pulse that zeroes the counter.
- state, output, 2: FSM state, encoded 00 STOPPED, 01 RUNNING, 10 LAP; 11 is unused.

Behaviour:
- Reset (asynchronous, any time, including mid-debounce) clears the following:
  - sync flops, debounced states, debounce counters and edge registers → 0;
  - state = STOPPED;
  - outputs: run = 0, freeze = 0, clear = 0.
- Synchroniser: two flops per button. The debounce logic sees only the second flop.
- Debounce, per button, independent of the other buttons:
  - If sync == debounced: the counter is held at 0.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1 while sync still differs, debounced takes sync and the counter returns to 0 on the same edge.
  - Any cycle with sync == debounced restarts the count (glitch rejection).
- Press event: a one-cycle internal pulse generated on a debounced 0→1 transition. Release (1→0) generates no event.
- Latency: a raw input that rises and then stays high produces its output effect (new run/freeze/state, or the clear pulse) on exactly the (DEBOUNCE_CYCLES + 3)th rising edge after the first edge that samples it high. All outputs are registered.
- FSM outputs per state:
  - STOPPED: run = 0, freeze = 0.
  - RUNNING: run = 1, freeze = 0.
  - LAP: run = 1, freeze = 1.
- FSM transitions (one event acted on per cycle; priority clear > startstop > lap; lower-priority events in the same cycle are discarded, not queued):
  - clear event, any state: clear = 1 for exactly one cycle. STOPPED stays STOPPED, RUNNING stays RUNNING, LAP → RUNNING (freeze released).
  - startstop event: STOPPED → RUNNING; RUNNING → STOPPED; LAP → STOPPED (freeze released).
  - lap event: RUNNING → LAP; LAP → RUNNING; in STOPPED it is ignored.
- A button held indefinitely produces exactly one event. A new event needs a debounced release followed by a new debounced press.
- clear is never high for two consecutive cycles.
- state 11 is unreachable; if it is entered, the next edge goes to STOPPED.

Test Plan (DEBOUNCE_CYCLES=4):
1. Reset, then hold btn_startstop high from edge 0 → run = 1 and state = 01 first seen after edge 7; they stay so while the button is held. Release then re-press → run = 0, state = 00.
2. Glitches: btn_lap pulses high for 3 cycles, low for 1, high for 3 while RUNNING → no state change (state stays 01, freeze = 0). Holding it for 4 or more stable cycles → state = 10, freeze = 1, run = 1.
3. LAP, then press lap again → state = 01, freeze = 0. LAP, then press startstop → state = 00, run = 0, freeze = 0.
4. Press btn_clear in each of STOPPED, RUNNING and LAP → clear high for exactly one cycle each time. Resulting states: 00, 01 and 01 respectively.
5. btn_clear and btn_startstop rise on the same edge while RUNNING → one clear pulse, state stays 01, startstop lost. Repeat with btn_startstop and btn_lap together in RUNNING → state = 00.
6. Assert reset midway through a debounce count (counter = 2) and while in LAP → run = 0, freeze = 0, clear = 0, state = 00 immediately, without a clock edge. After release with the button still held: an event only after a full DEBOUNCE_CYCLES + 3 edges.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// Pushbutton front end for the stopwatch. Each button is synchronised, debounced and
// edge-detected, and the resulting press events drive a small run/lap/clear controller.
module stopwatch_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_W           = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_startstop,
    input  logic       btn_lap,
    input  logic       btn_clear,
    output logic       run,
    output logic       freeze,
    output logic       clear,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        ST_STOPPED = 2'b00,
        ST_RUNNING = 2'b01,
        ST_LAP     = 2'b10
    } state_e;

    localparam int IDX_SS  = 0;
    localparam int IDX_LAP = 1;
    localparam int IDX_CLR = 2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [2:0]       btn_raw;
    logic [2:0]       sync1_q;
    logic [2:0]       sync2_q;
    logic [2:0]       deb_q;
    logic [2:0]       deb_d;
    logic [2:0]       deb_prev_q;
    logic [2:0]       press_q;
    logic [CNT_W-1:0] cnt_q [3];
    logic [CNT_W-1:0] cnt_d [3];

    state_e state_q;
    state_e state_d;
    logic   run_q;
    logic   freeze_q;
    logic   clear_q;
    logic   clear_d;

    assign btn_raw = {btn_clear, btn_lap, btn_startstop};

    // Counter runs only while the synchronised input disagrees with the debounced level;
    // any agreeing cycle restarts it, so short glitches never reach the FSM.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        for (int i = 0; i < 3; i++) begin
            deb_d[i] = deb_q[i];
            cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            press_q    <= '0;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q    <= btn_raw;
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            press_q    <= deb_q & ~deb_prev_q;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // One event per cycle: clear beats start/stop beats lap; losers are dropped.
    always_comb begin
        state_d = state_q;
        clear_d = press_q[IDX_CLR];
        case (state_q)
            ST_STOPPED: begin
                if (!press_q[IDX_CLR] && press_q[IDX_SS]) state_d = ST_RUNNING;
            end
            ST_RUNNING: begin
                if (!press_q[IDX_CLR]) begin
                    if (press_q[IDX_SS])       state_d = ST_STOPPED;
                    else if (press_q[IDX_LAP]) state_d = ST_LAP;
                end
            end
            ST_LAP: begin
                if (press_q[IDX_CLR])      state_d = ST_RUNNING;
                else if (press_q[IDX_SS])  state_d = ST_STOPPED;
                else if (press_q[IDX_LAP]) state_d = ST_RUNNING;
            end
            default: state_d = ST_STOPPED;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_STOPPED;
            run_q    <= 1'b0;
            freeze_q <= 1'b0;
            clear_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            run_q    <= (state_d == ST_RUNNING) || (state_d == ST_LAP);
            freeze_q <= (state_d == ST_LAP);
            clear_q  <= clear_d;
        end
    end

    assign run    = run_q;
    assign freeze = freeze_q;
    assign clear  = clear_q;
    assign state  = state_q;

endmodule
